riscv_regfile_scoreboard: RTL
=============================

RISCV_REGFILE_SCOREBOARD -- requirements
Module: riscv_regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, architectural register count; legal values 16 (RV32E) or 32.
REQ-003 The block SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding when 1.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high: clock  input  1  rising-edge clock.
REQ-005 The block SHALL have: reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have: rs1_addr, rs2_addr  input  5 each  read addresses.
REQ-007 The block SHALL have: rs1_data, rs2_data  output  XLEN each  combinational read data.
REQ-008 The block SHALL have: rs1_busy, rs2_busy  output  1 each  source register has an outstanding producer.
REQ-009 The block SHALL have: rd_addr  input  5, rd_enable_write  input  1, rd_data  input  XLEN  writeback port.
REQ-010 The block SHALL have: issue_valid  input  1, issue_rd  input  5  marks a destination register pending.
REQ-011 The block SHALL have: ready  output  1  high once post-reset clearing is complete.
REQ-012 The block SHALL have: illegal_access  output  1  sticky flag for any out-of-range access.

Function
REQ-013 FSM states SHALL be CLEAR and RUN; reset forces CLEAR with clear pointer = 1.
REQ-014 In CLEAR, each cycle with reset low SHALL zero register[ptr]; if ptr == NUM_REGS-1 go to RUN, else ptr+1.
REQ-015 ready SHALL be 1 only in RUN; after reset deassert, ready rises after exactly NUM_REGS-1 clock edges.
REQ-016 In CLEAR, writes and issues SHALL be ignored; rs*_data and rs*_busy SHALL read 0.
REQ-017 Register x0 SHALL always read 0, never be written, and never be busy.
REQ-018 Address >= NUM_REGS: reads return 0 with busy 0; writes and issues are dropped; in RUN, illegal_access sets and holds until reset.
REQ-019 Illegal check SHALL apply to rs1_addr/rs2_addr unconditionally, to rd_addr only when rd_enable_write, and to issue_rd only when issue_valid.
REQ-020 Write in RUN (enable, rd != 0, in range) SHALL update register[rd_addr] at the clock edge and clear busy[rd_addr].
REQ-021 Issue in RUN (valid, issue_rd != 0, in range) SHALL set busy[issue_rd] at the clock edge.
REQ-022 Same-cycle issue and write to the same register: data written, busy ends set (set wins).
REQ-023 BYPASS=1: when a valid write targets a read address in the same cycle, rs*_data = rd_data and rs*_busy = 0.
REQ-024 BYPASS=0: reads return stored value and registered busy; the new value is visible the next cycle.
REQ-025 Both read ports SHALL be independent; identical addresses return identical data and busy.

Reset
REQ-026 Reset SHALL clear all busy bits, illegal_access, and ready in the same edge; rs*_data reads 0 while reset is high or in CLEAR.
REQ-027 Reset asserted mid-CLEAR SHALL restart clearing from ptr = 1; reset mid-RUN SHALL discard pending state.

Verification
REQ-028 Reset 1 cycle, NUM_REGS=32 -> ready 0 for 31 edges, 1 after; every register reads 0.
REQ-029 Write x5=0xDEADBEEF, read rs1=5 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0 then 0xDEADBEEF next cycle.
REQ-030 Issue rd=7, then rs2=7 -> busy 1; write x7=0x12 -> busy 0 (same cycle if BYPASS=1), data 0x12.
REQ-031 Same cycle: issue rd=9 and write x9=0x55 -> next cycle x9=0x55, busy 1.
REQ-032 NUM_REGS=16: write x20=0x1 -> dropped, illegal_access 1 sticky; rs1=20 reads 0; x0 write 0xFF reads 0, illegal stays from prior only.
REQ-033 Reset pulsed at clear ptr=10 -> ready delayed to 31 edges after the second deassert.

Source files
------------

// File: rtl/riscv_regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, writeback, issue, status.
// master drives addresses, writeback and issue; slave returns data/busy/status.
interface riscv_regfile_scoreboard_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      rd_addr;
  logic            rd_enable_write;
  logic [XLEN-1:0] rd_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            ready;
  logic            illegal_access;

  modport master (
    output rs1_addr, rs2_addr,
    output rd_addr, rd_enable_write, rd_data,
    output issue_valid, issue_rd,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy,
    input  ready, illegal_access
  );

  modport slave (
    input  rs1_addr, rs2_addr,
    input  rd_addr, rd_enable_write, rd_data,
    input  issue_valid, issue_rd,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy,
    output ready, illegal_access
  );
endinterface

// File: rtl/riscv_regfile_scoreboard.sv
// Register file with busy scoreboard and post-reset sequential clearing.
// Ports: clock, reset (sync, active-high), rf (slave bus: reads/write/issue).
module riscv_regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int BYPASS   = 1
) (
  input  logic clock,
  input  logic reset,
  riscv_regfile_scoreboard_if.slave rf
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic            illegal_q;
  logic            live, wr_ok, iss_ok, bad;

  function automatic logic in_range(input logic [4:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // live: normal operation this cycle (not clearing, not in reset)
  assign live   = (state_q == RUN) && !reset;
  assign wr_ok  = live && rf.rd_enable_write &&
                  (rf.rd_addr != 5'd0) && in_range(rf.rd_addr);
  assign iss_ok = live && rf.issue_valid &&
                  (rf.issue_rd != 5'd0) && in_range(rf.issue_rd);
  assign bad    = !in_range(rf.rs1_addr) || !in_range(rf.rs2_addr) ||
                  (rf.rd_enable_write && !in_range(rf.rd_addr)) ||
                  (rf.issue_valid && !in_range(rf.issue_rd));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      if (ptr_q == AW'(NUM_REGS - 1)) state_d = RUN;
      else ptr_d = ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // x0 is never stored; reads of it are forced to zero instead
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) regs[ptr_q] <= '0;
      else if (wr_ok) regs[rf.rd_addr[AW-1:0]] <= rf.rd_data;
    end
  end

  // issue is applied after writeback so a same-cycle pair leaves busy set
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (wr_ok) busy_q[rf.rd_addr[AW-1:0]] <= 1'b0;
      if (iss_ok) busy_q[rf.issue_rd[AW-1:0]] <= 1'b1;
      if (live && bad) illegal_q <= 1'b1;
    end
  end

  function automatic logic [XLEN:0] rd_port(input logic [4:0] a);
    logic [XLEN:0] r;
    r = '0;
    if (live && (a != 5'd0) && in_range(a)) begin
      if ((BYPASS != 0) && wr_ok && (rf.rd_addr == a))
        r = {1'b0, rf.rd_data};
      else
        r = {busy_q[a[AW-1:0]], regs[a[AW-1:0]]};
    end
    return r;
  endfunction

  always_comb begin
    {rf.rs1_busy, rf.rs1_data} = rd_port(rf.rs1_addr);
    {rf.rs2_busy, rf.rs2_data} = rd_port(rf.rs2_addr);
  end

  assign rf.ready          = (state_q == RUN);
  assign rf.illegal_access = illegal_q;
endmodule
